// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants and FSM state type for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 64;
  localparam int SEL_W = 6;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_arb_if: requester bus (req, release_i) and arbiter results (sel, gnt, grant_valid, timeout)
interface mux_arb_if import mux_arb_pkg::*; #(
  parameter int N = N_REQ,
  parameter int SEL_W = mux_arb_pkg::SEL_W
);
  logic [N-1:0] req;
  logic release_i;
  logic [SEL_W-1:0] sel;
  logic [N-1:0] gnt;
  logic grant_valid;
  logic timeout;
  modport master (output req, release_i, input sel, gnt, grant_valid, timeout);
  modport slave (input req, release_i, output sel, gnt, grant_valid, timeout);
endinterface

// File: rtl/multiplexor6.sv
// multiplexor6: 64:1 bit mux; in[63:0], sel[5:0] -> out = in[sel]
module multiplexor6 (
  input  logic [63:0] in,
  input  logic [5:0]  sel,
  output logic        out
);
  assign out = in[sel];
endmodule

// File: rtl/mux_rr_arbiter_pick.sv
// rr_pick: combinational first-set search from ptr_i with wrap; req_i, ptr_i -> idx_o, any_o
module rr_pick import mux_arb_pkg::*; #(
  parameter int N = N_REQ,
  parameter int SEL_W = mux_arb_pkg::SEL_W
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);
  logic [N-1:0] rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0] sum;
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N; i++) rot[i] = req_i[(i + int'(ptr_i)) % N];
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
    sum = {1'b0, off} + {1'b0, ptr_i};
    idx_o = sum >= (SEL_W+1)'(N) ? SEL_W'(sum - (SEL_W+1)'(N)) : SEL_W'(sum);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a 64:1 mux; clk, rst_n (async low), bus.slave (req/release_i in, sel/gnt/grant_valid/timeout out)
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter int N = N_REQ,
  parameter int SEL_W = mux_arb_pkg::SEL_W,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst_n,
  mux_arb_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD);
  arb_state_t state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, pick_idx;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic gv_q, gv_d, to_q, to_d, pick_any, owner_req, hold_max, end_grant;
  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  assign owner_req = bus.req[sel_q];
  assign hold_max = hold_q == HW'(MAX_HOLD - 1);
  assign end_grant = state_q == BUSY && (bus.release_i || !owner_req || hold_max);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      hold_q <= '0;
      sel_q <= '0;
      gnt_q <= '0;
      gv_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
      gv_q <= gv_d;
      to_q <= to_d;
    end
  end
  always_comb state_d = state_q == IDLE ? (pick_any ? BUSY : IDLE) : (end_grant ? IDLE : BUSY);
  always_comb begin
    sel_d = state_q == IDLE && pick_any ? pick_idx : sel_q;
    gv_d = state_d == BUSY;
    gnt_d = gv_d ? N'(1) << sel_d : '0;
    to_d = end_grant && !bus.release_i && owner_req;
    ptr_d = end_grant ? (sel_q == SEL_W'(N - 1) ? '0 : sel_q + 1'b1) : ptr_q;
    hold_d = state_q == BUSY && !end_grant ? hold_q + 1'b1 : '0;
  end
  assign bus.sel = sel_q;
  assign bus.gnt = gnt_q;
  assign bus.grant_valid = gv_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of mux_rr_arbiter + multiplexor6 against a behavioural model
module tb_mux_rr_arbiter;
  localparam int N = 64;
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic mux_out;
  int n_checks = 0;
  int n_fail = 0;
  bit m_busy;
  bit m_to;
  int m_sel, m_ptr, m_hold;
  logic [63:0] cur_r;
  mux_arb_if #(.N(N), .SEL_W(6)) bus ();
  mux_rr_arbiter #(.N(N), .SEL_W(6), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multiplexor6 u_mux (.in(bus.req), .sel(bus.sel), .out(mux_out));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0;
    m_to = 0;
    m_sel = 0;
    m_ptr = 0;
    m_hold = 0;
  endtask
  task automatic model_step(input logic [63:0] r, input logic rel);
    bit by_rel, by_drop, by_hold;
    m_to = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++)
        if (r[(m_ptr + k) % N]) begin
          m_sel = (m_ptr + k) % N;
          m_busy = 1;
          m_hold = 0;
          break;
        end
    end else begin
      by_rel = rel;
      by_drop = !r[m_sel];
      by_hold = m_hold == MAX_HOLD - 1;
      if (by_rel || by_drop || by_hold) begin
        m_busy = 0;
        m_ptr = (m_sel + 1) % N;
        m_to = by_hold && !by_rel && !by_drop;
      end else m_hold++;
    end
  endtask
  task automatic check_all();
    check("sel", 64'(bus.sel), 64'(m_sel));
    check("gnt", bus.gnt, m_busy ? 64'd1 << m_sel : 64'd0);
    check("grant_valid", 64'(bus.grant_valid), 64'(m_busy));
    check("timeout", 64'(bus.timeout), 64'(m_to));
    check("mux_out", 64'(mux_out), 64'(cur_r[m_sel]));
  endtask
  task automatic step(input logic [63:0] r, input logic rel);
    cur_r = r;
    bus.req = r;
    bus.release_i = rel;
    model_step(r, rel);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [63:0] r;
    rst_n = 1'b0;
    cur_r = '0;
    bus.req = '0;
    bus.release_i = 1'b0;
    model_reset();
    #12 check_all();
    rst_n = 1'b1;
    step(64'd1 << 5, 0);
    step(64'd1 << 5, 0);
    check("grant5", 64'(bus.sel), 64'd5);
    do_reset();
    check("rst_gv", 64'(bus.grant_valid), 64'd0);
    step(64'd1 << 7, 0);
    check("after_rst_sel7", 64'(bus.sel), 64'd7);
    do_reset();
    for (int i = 0; i < 130; i++) begin
      step('1, 1);
      if (i % 2 == 0) check("rr_seq", 64'(bus.sel), 64'((i / 2) % 64));
      check("onehot", 64'($onehot0(bus.gnt)), 64'd1);
    end
    do_reset();
    step(64'd1 << 61, 0);
    step(64'd1 << 61, 1);
    step((64'd1 << 63) | (64'd1 << 3), 0);
    check("wrap63", 64'(bus.sel), 64'd63);
    step((64'd1 << 63) | (64'd1 << 3), 1);
    step((64'd1 << 63) | (64'd1 << 3), 0);
    check("wrap3", 64'(bus.sel), 64'd3);
    step(64'd1 << 3, 1);
    step(64'd1 << 3, 0);
    check("only3", 64'(bus.sel), 64'd3);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(64'd1 << 10, 0);
      check("to_hold_gv", 64'(bus.grant_valid), 64'd1);
    end
    step(64'd1 << 10, 0);
    check("to_pulse", 64'(bus.timeout), 64'd1);
    step((64'd1 << 10) | (64'd1 << 12), 0);
    check("to_next12", 64'(bus.sel), 64'd12);
    do_reset();
    for (int i = 0; i < 3; i++) step(64'd1 << 20, 0);
    step(64'd0, 0);
    check("drop_gv", 64'(bus.grant_valid), 64'd0);
    check("drop_to", 64'(bus.timeout), 64'd0);
    step((64'd1 << 20) | (64'd1 << 21), 0);
    check("drop_ptr21", 64'(bus.sel), 64'd21);
    do_reset();
    for (int i = 0; i < 16; i++) step(64'd1 << 30, 0);
    step(64'd1 << 30, 1);
    check("simul_to", 64'(bus.timeout), 64'd0);
    check("simul_gv", 64'(bus.grant_valid), 64'd0);
    step(64'd0, 1);
    check("idle_rel_gv", 64'(bus.grant_valid), 64'd0);
    check("idle_rel_sel", 64'(bus.sel), 64'd30);
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom % 8 == 0) r = '0;
      step(r, $urandom % 6 == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
